// File: rtl/pulse_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_meter_pkg
//  Description : Shared types and constants for the pulse propagation time
//                meter measurement stage.
//                - state_t           : measurement FSM states
//                - c_default_width   : default interval counter width
//                - c_min_sync_stages : smallest legal synchroniser depth
//                - sync_stages_clamp : raises a requested depth to the minimum
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_meter_pkg;

  // Measurement controller states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Default width of the interval counter and of the reported result.
  localparam int c_default_width = 16;

  // Fewer than two flops gives no metastability settling time at all.
  localparam int c_min_sync_stages = 2;

  // A depth below the minimum is raised to the minimum rather than producing
  // a synchroniser that cannot do its job.
  function automatic int sync_stages_clamp(input int stages);
    return (stages < c_min_sync_stages) ? c_min_sync_stages : stages;
  endfunction

endpackage : pulse_meter_pkg
`default_nettype wire

// File: rtl/level_sync.sv
`default_nettype none
// ============================================================================
//  Module      : level_sync
//  Description : Brings an asynchronous level into the i_Clk domain through a
//                chain of SYNC_STAGES flops and flags its rising transition.
//
//  Parameters  : SYNC_STAGES - synchroniser depth (values below the package
//                              minimum are raised to it)
//
//  Ports       : i_Clk   - system clock
//                i_Rst   - asynchronous active-high reset
//                i_Level - asynchronous input level
//                o_Level - synchronised level
//                o_Rise  - one-cycle pulse: synchronised level is 1 and was
//                          0 on the previous cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module level_sync
  import pulse_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Level,
  output logic o_Level,
  output logic o_Rise
);

  localparam int c_stages = sync_stages_clamp(SYNC_STAGES);

  logic [c_stages-1:0] r_sync;
  logic                r_prev;

  // Synchroniser chain: stage 0 samples the raw asynchronous level, every
  // following stage samples its predecessor.
  genvar g_idx;
  for (g_idx = 0; g_idx < c_stages; g_idx++) begin : g_stage
    if (g_idx == 0) begin : g_first
      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          r_sync[0] <= 1'b0;
        end else begin
          r_sync[0] <= i_Level;
        end
      end
    end else begin : g_next
      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          r_sync[g_idx] <= 1'b0;
        end else begin
          r_sync[g_idx] <= r_sync[g_idx-1];
        end
      end
    end
  end

  // Previous synchronised value for the edge detector. Because it also
  // resets to 0, a level that is already high when reset releases still
  // produces exactly one rise once it has propagated through the chain.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= r_sync[c_stages-1];
    end
  end

  assign o_Level = r_sync[c_stages-1];
  assign o_Rise  = r_sync[c_stages-1] & ~r_prev;

endmodule : level_sync
`default_nettype wire

// File: rtl/pulse_interval_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_interval_counter
//  Description : Measures the number of i_Clk cycles between the rising edge
//                of a start level and the rising edge of a stop level, and
//                presents the result with a valid/ack handshake.
//
//  Parameters  : WIDTH       - interval counter / result width
//                SYNC_STAGES - synchroniser depth for each level input
//
//  Ports       : i_Clk         - system clock
//                i_Rst         - asynchronous active-high reset
//                i_Start_Level - asynchronous launch level
//                i_Stop_Level  - asynchronous arrival level
//                i_Arm         - request a measurement (honoured in IDLE)
//                i_Ack         - result consumed (honoured in DONE)
//                o_Busy        - measurement in progress (ARMED/COUNTING)
//                o_Valid       - result available (DONE)
//                o_Count       - measured interval in clock cycles
//                o_Overflow    - interval saturated at 2^WIDTH-1
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_interval_counter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH       = c_default_width,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start_Level,
  input  logic             i_Stop_Level,
  input  logic             i_Arm,
  input  logic             i_Ack,
  output logic             o_Busy,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Count,
  output logic             o_Overflow
);

  // Largest reportable interval, and the counter value on which the FSM
  // gives up waiting: reporting counter+1 from here yields exactly
  // c_count_max, so the counter itself never needs to wrap.
  localparam logic [WIDTH-1:0] c_count_max = '1;
  localparam logic [WIDTH-1:0] c_sat_limit = c_count_max - 1'b1;

  // --------------------------------------------------------------------------
  // Input synchronisation and edge detection. Both channels use the same
  // depth so their latency is identical and cancels in the measured interval.
  // --------------------------------------------------------------------------
  logic w_start_rise;
  logic w_stop_rise;
  logic w_start_level;
  logic w_stop_level;
  logic [1:0] w_unused_levels;

  level_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_start_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Level (i_Start_Level),
    .o_Level (w_start_level),
    .o_Rise  (w_start_rise)
  );

  level_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_stop_sync (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Level (i_Stop_Level),
    .o_Level (w_stop_level),
    .o_Rise  (w_stop_rise)
  );

  // Only the edges matter here; the synchronised levels are kept available
  // for debug taps but are not used by the controller.
  assign w_unused_levels = {w_start_level, w_stop_level};

  // --------------------------------------------------------------------------
  // Measurement controller, interval counter and output registers.
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_count;
  logic             r_overflow;
  logic             r_busy;
  logic             r_valid;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state    <= IDLE;
      r_counter  <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_Arm) begin
            r_state    <= ARMED;
            r_counter  <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        // A stop edge without a start edge is simply not looked at here.
        ARMED: begin
          if (w_start_rise) begin
            if (w_stop_rise) begin
              // Launch and arrival resolved to the same cycle.
              r_state <= DONE;
              r_count <= '0;
              r_busy  <= 1'b0;
              r_valid <= 1'b1;
            end else begin
              r_state   <= COUNTING;
              r_counter <= '0;
            end
          end
        end

        // The counter lags the true interval by one cycle because it starts
        // at 0 on the cycle after the start edge; the +1 on the stop edge
        // makes the result equal to the edge-to-edge distance. A stop edge on
        // the saturation cycle still reports a genuine (non-overflow) value.
        COUNTING: begin
          if (w_stop_rise) begin
            r_state <= DONE;
            r_count <= r_counter + 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
          end else if (r_counter == c_sat_limit) begin
            r_state    <= DONE;
            r_count    <= c_count_max;
            r_overflow <= 1'b1;
            r_busy     <= 1'b0;
            r_valid    <= 1'b1;
          end else begin
            r_counter <= r_counter + 1'b1;
          end
        end

        // Result is frozen until acknowledged; edges seen here are dropped.
        DONE: begin
          if (i_Ack) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_Busy     = r_busy;
  assign o_Valid    = r_valid;
  assign o_Count    = r_count;
  assign o_Overflow = r_overflow;

endmodule : pulse_interval_counter
`default_nettype wire

// File: tb/tb_pulse_interval_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_interval_counter
//  Description : Self-checking bench for pulse_interval_counter. Levels are
//                driven synchronously to the clock; the expected interval is
//                the number of cycles between raising start and raising stop,
//                saturating at 2^WIDTH-1 with the overflow flag set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_interval_counter;

  localparam int WIDTH       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int COUNT_MAX   = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_lvl;
  logic             stop_lvl;
  logic             arm;
  logic             ack;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] count;
  logic             ovf;

  int checks  = 0;
  int errors  = 0;
  int lat_ref = -1;

  always #5 clk = ~clk;

  pulse_interval_counter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_dut (
    .i_Clk         (clk),
    .i_Rst         (rst),
    .i_Start_Level (start_lvl),
    .i_Stop_Level  (stop_lvl),
    .i_Arm         (arm),
    .i_Ack         (ack),
    .o_Busy        (busy),
    .o_Valid       (valid),
    .o_Count       (count),
    .o_Overflow    (ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: d = cycles from start raise to stop raise (negative = never).
  function automatic void ref_model(input int d, output int cnt, output bit of);
    if (d < 0 || d > COUNT_MAX) begin
      cnt = COUNT_MAX;
      of  = 1'b1;
    end else begin
      cnt = d;
      of  = 1'b0;
    end
  endfunction

  // One full measurement from IDLE: arm, raise start, raise stop d cycles
  // later, wait for the result, hold it for 'hold' cycles, acknowledge.
  // With noise set, i_Arm is pulsed during COUNTING, during DONE and
  // together with i_Ack.
  task automatic measure(input int d, input int hold, input bit noise, output int vlat);
    int               exp_cnt;
    bit               exp_of;
    bit               got;
    bit               changed;
    logic [WIDTH-1:0] held;
    ref_model(d, exp_cnt, exp_of);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("busy_after_arm", busy, 1);
    tick();
    tick();
    start_lvl = 1'b1;
    if (d == 0) stop_lvl = 1'b1;
    got  = 1'b0;
    vlat = -1;
    for (int n = 1; n <= COUNT_MAX + 50; n++) begin
      tick();
      arm = 1'b0;
      if (valid) begin
        got  = 1'b1;
        vlat = n;
        break;
      end
      if (n == d) stop_lvl = 1'b1;
      if (noise && n == 5) arm = 1'b1;
    end
    arm = 1'b0;
    check("valid_seen", got, 1);
    check("count", count, exp_cnt);
    check("overflow", ovf, exp_of);
    check("busy_in_done", busy, 0);
    if (lat_ref >= 0) begin
      if (exp_of) check("ovf_latency", vlat, COUNT_MAX + lat_ref);
      else        check("valid_latency", vlat, d + lat_ref);
    end
    held    = count;
    changed = 1'b0;
    for (int k = 0; k < hold; k++) begin
      arm = (noise && k == hold / 2);
      tick();
      if (valid !== 1'b1 || count !== held || ovf !== exp_of || busy !== 1'b0) changed = 1'b1;
    end
    arm = 1'b0;
    if (hold > 0) check("hold_stable", changed, 0);
    ack = 1'b1;
    arm = noise;
    tick();
    ack = 1'b0;
    arm = 1'b0;
    check("valid_after_ack", valid, 0);
    check("busy_after_ack", busy, 0);
    tick();
    check("arm_with_ack_ignored", busy, 0);
    start_lvl = 1'b0;
    stop_lvl  = 1'b0;
    repeat (SYNC_STAGES + 3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  v;
    int  d;
    bit  got;
    bit  seen;
    rst       = 1'b1;
    arm       = 1'b0;
    ack       = 1'b0;
    start_lvl = 1'b0;
    stop_lvl  = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    tick();

    // Basic interval; establishes the fixed input-to-valid latency.
    measure(100, 0, 1'b0, v);
    lat_ref = (v >= 0) ? v - 100 : -1;

    // Start and stop together, then start with no stop (saturation).
    measure(0, 0, 1'b0, v);
    measure(-1, 0, 1'b0, v);

    // Stop raised before start is ignored; the re-raised stop counts.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    stop_lvl = 1'b1;
    repeat (20) tick();
    start_lvl = 1'b1;
    got = 1'b0;
    for (int n = 1; n <= COUNT_MAX + 50; n++) begin
      tick();
      if (valid) begin
        got = 1'b1;
        break;
      end
      if (n == 5)  stop_lvl = 1'b0;
      if (n == 30) stop_lvl = 1'b1;
    end
    check("stop_first_valid", got, 1);
    check("stop_first_count", count, 30);
    check("stop_first_ovf", ovf, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    start_lvl = 1'b0;
    stop_lvl  = 1'b0;
    repeat (SYNC_STAGES + 3) tick();

    // Reset in the middle of COUNTING aborts at once with no result.
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    start_lvl = 1'b1;
    repeat (13) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_count", count, 0);
    check("abort_ovf", ovf, 0);
    start_lvl = 1'b0;
    tick();
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (valid) seen = 1'b1;
    end
    check("no_valid_after_abort", seen, 0);

    // Fresh measurement with stray arms and a long unacknowledged hold.
    measure(50, 200, 1'b1, v);

    // Saturation boundaries and randomized intervals.
    for (int t = 0; t < 10; t++) begin
      case (t)
        0:       d = COUNT_MAX - 1;
        1:       d = COUNT_MAX;
        2:       d = COUNT_MAX + 1;
        3:       d = 1;
        default: d = int'($urandom_range(0, 300));
      endcase
      measure(d, int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pulse_interval_counter
`default_nettype wire

// File: doc/pulse_interval_counter.md
# pulse_interval_counter

Downstream measurement stage of the pulse propagation time meter. Takes two latched level signals: start (launch pulse) and stop (arrival pulse), each produced by an upstream pulse-to-level latch. Synchronises both into the system clock domain and counts clock cycles between their rising edges. Presents the result with a valid/ack handshake to the readout logic.

## Interface
- WIDTH, 16: width of the interval counter and result.
- SYNC_STAGES, 2: flip-flop stages in each level synchroniser; minimum 2.

- i_Clk, input, 1: system clock; all state changes on rising edge.
- i_Rst, input, 1: reset, asynchronous, active-high.
- i_Start_Level, input, 1: asynchronous start level; a rising transition marks launch.
- i_Stop_Level, input, 1: asynchronous stop level; a rising transition marks arrival.
- i_Arm, input, 1: single-cycle request to begin a measurement; honoured only in IDLE.
- i_Ack, input, 1: readout consumed result; honoured only in DONE.
- o_Busy, output, 1: high in ARMED and COUNTING.
- o_Valid, output, 1: high in DONE; o_Count/o_Overflow stable while high.
- o_Count, output, WIDTH: measured interval in clock cycles.
- o_Overflow, output, 1: interval reached 2^WIDTH-1 before stop edge.

## Operation
- Each level passes through a SYNC_STAGES synchroniser followed by an edge detector. Edge = synchronised value 1 and previous synchronised value 0, for one cycle.
- States: IDLE, ARMED, COUNTING, DONE.
- IDLE: when i_Arm=1, go to ARMED, clear counter, clear o_Overflow.
- ARMED: wait for a start edge. A stop edge seen before the start edge is ignored.
  - Start edge alone: go to COUNTING with counter = 0.
  - Start and stop edges in the same cycle: go to DONE with o_Count = 0.
- COUNTING: the counter increments by 1 every cycle.
  - Stop edge: o_Count <= counter + 1; go to DONE.
  - Counter = 2^WIDTH-2 with no stop edge: o_Count <= 2^WIDTH-1 and o_Overflow <= 1; go to DONE. The counter never wraps.
  - Additional start edges are ignored.
- DONE: o_Valid=1. When i_Ack=1, go to IDLE. Edges arriving in DONE are discarded; they are not queued.
- i_Arm outside IDLE and i_Ack outside DONE have no effect.
- Levels that are already high when the block is armed produce no edge. Upstream latches must return low between measurements; otherwise ARMED waits indefinitely. o_Busy tells the controller this is happening.

## Timing
- All outputs reset to 0. State resets to IDLE, counter to 0, and every synchroniser and edge-detect flop to 0.
- Reset asserted mid-measurement aborts immediately. No o_Valid is produced for the aborted measurement.
- Input-to-edge latency is SYNC_STAGES+1 cycles. It is identical on both channels, so it cancels in the result.
- Let a start edge be detected on cycle N and a stop edge on cycle M, with M > N. Then o_Count = M−N and o_Valid rises on cycle M+1.
- Resolution is ±1 clock cycle from synchroniser uncertainty.
- o_Busy rises the cycle after i_Arm and falls when DONE is entered.
- o_Valid falls the cycle after i_Ack.
- i_Arm asserted in the same cycle as i_Ack has no effect. The earliest re-arm is the cycle after return to IDLE.

## Structure
- Shared package pulse_meter_pkg holds:
  - the state enum (IDLE, ARMED, COUNTING, DONE);
  - the default counter width constant;
  - the minimum SYNC_STAGES constant.
- Sub-module level_sync (parameter SYNC_STAGES; ports i_Clk, i_Rst, i_Level, o_Level, o_Rise) is instantiated once per channel.
- Top level contains the FSM, counter, saturation logic and output registers.

## Test plan
- Arm, raise start, raise stop 100 clocks later (both synchronous to i_Clk) -> o_Valid once, o_Count=100, o_Overflow=0. After i_Ack, o_Valid=0 next cycle and o_Busy=0.
- WIDTH=8, arm, raise start, never raise stop -> o_Count=255, o_Overflow=1, o_Valid after 255 counting cycles.
- Arm, raise start and stop on the same cycle -> o_Count=0, o_Valid=1.
- Raise stop, then start 20 clocks later, then lower and re-raise stop 30 clocks after start -> first stop ignored, o_Count=30.
- Assert i_Rst 10 clocks into COUNTING -> all outputs 0 immediately. No o_Valid. After release, a fresh 50-clock measurement returns o_Count=50.
- Pulse i_Arm while in COUNTING and DONE -> no state change. Hold the result without i_Ack for 200 clocks -> o_Count and o_Valid remain stable.
